// File: rtl/muldiv_hilo_ctrl.sv
// EX-stage sequencer for the shared multi-cycle multiplier/divider: one HI/LO write per accepted op,
// stall held from accept until DONE, flush/watchdog abort with divider annul, divide-by-zero bypass.
module muldiv_hilo_ctrl #(
  parameter int WDOG_CYCLES = 48,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic        flush_i,
  output logic        mul_start_o,
  output logic        mul_signed_o,
  output logic [31:0] mul_op1_o,
  output logic [31:0] mul_op2_o,
  input  logic [63:0] mul_result_i,
  input  logic        mul_ready_i,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic        div_annul_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        stall_req_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        wdog_err_o
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [CNT_W-1:0] WDOG_LIMIT = CNT_W'(WDOG_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_BUSY,
    S_DIV_BUSY,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              mul_start_q, mul_start_d;
  logic              div_start_q, div_start_d;
  logic              div_annul_q, div_annul_d;
  logic              sgn_q, sgn_d;
  logic [31:0]       op1_q, op1_d;
  logic [31:0]       op2_q, op2_d;
  logic              hilo_we_q, hilo_we_d;
  logic [31:0]       hi_q, hi_d;
  logic [31:0]       lo_q, lo_d;
  logic              wdog_err_q, wdog_err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              is_mul;
  logic              is_div;
  logic              accept;
  logic [CNT_W-1:0]  cnt_inc;
  logic              wdog_hit;

  assign is_mul   = (op_i == OP_MULT) || (op_i == OP_MULTU);
  assign is_div   = (op_i == OP_DIV)  || (op_i == OP_DIVU);
  assign accept   = (state_q == S_IDLE) && ex_valid_i && (is_mul || is_div) && !flush_i;
  assign cnt_inc  = cnt_q + CNT_W'(1);
  assign wdog_hit = (cnt_inc == WDOG_LIMIT);

  always_comb begin
    state_d     = state_q;
    mul_start_d = mul_start_q;
    div_start_d = div_start_q;
    div_annul_d = 1'b0;
    sgn_d       = sgn_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    hilo_we_d   = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    wdog_err_d  = wdog_err_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op1_d = src1_i;
          op2_d = src2_i;
          sgn_d = (op_i == OP_MULT) || (op_i == OP_DIV);
          cnt_d = '0;
          if (is_mul) begin
            state_d     = S_MUL_BUSY;
            mul_start_d = 1'b1;
          end else if (src2_i != 32'd0) begin
            state_d     = S_DIV_BUSY;
            div_start_d = 1'b1;
          end else begin
            // Divide by zero never reaches the divider; architected result is produced here.
            state_d   = S_DONE;
            hi_d      = src1_i;
            lo_d      = 32'hFFFF_FFFF;
            hilo_we_d = 1'b1;
          end
        end
      end

      S_MUL_BUSY: begin
        cnt_d = cnt_inc;
        if (flush_i) begin
          state_d     = S_IDLE;
          mul_start_d = 1'b0;
        end else if (mul_ready_i) begin
          state_d     = S_DONE;
          mul_start_d = 1'b0;
          hi_d        = mul_result_i[63:32];
          lo_d        = mul_result_i[31:0];
          hilo_we_d   = 1'b1;
        end else if (wdog_hit) begin
          state_d     = S_IDLE;
          mul_start_d = 1'b0;
          wdog_err_d  = 1'b1;
        end
      end

      S_DIV_BUSY: begin
        cnt_d = cnt_inc;
        if (flush_i) begin
          state_d     = S_IDLE;
          div_start_d = 1'b0;
          div_annul_d = 1'b1;
        end else if (div_ready_i) begin
          state_d     = S_DONE;
          div_start_d = 1'b0;
          hi_d        = div_result_i[63:32];
          lo_d        = div_result_i[31:0];
          hilo_we_d   = 1'b1;
        end else if (wdog_hit) begin
          state_d     = S_IDLE;
          div_start_d = 1'b0;
          div_annul_d = 1'b1;
          wdog_err_d  = 1'b1;
        end
      end

      S_DONE: begin
        // The write strobe is already registered for this cycle; flush cannot retract it.
        state_d = S_IDLE;
      end

      default: begin
        state_d     = S_IDLE;
        mul_start_d = 1'b0;
        div_start_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      div_annul_q <= 1'b0;
      sgn_q       <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      hilo_we_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      wdog_err_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mul_start_q <= mul_start_d;
      div_start_q <= div_start_d;
      div_annul_q <= div_annul_d;
      sgn_q       <= sgn_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      hilo_we_q   <= hilo_we_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      wdog_err_q  <= wdog_err_d;
      cnt_q       <= cnt_d;
    end
  end

  // Same-cycle stall on accept so EX does not advance past the op being captured.
  assign stall_req_o  = accept || (state_q == S_MUL_BUSY) || (state_q == S_DIV_BUSY);

  assign mul_start_o  = mul_start_q;
  assign mul_signed_o = sgn_q;
  assign mul_op1_o    = op1_q;
  assign mul_op2_o    = op2_q;
  assign div_start_o  = div_start_q;
  assign div_signed_o = sgn_q;
  assign div_annul_o  = div_annul_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign hilo_we_o    = hilo_we_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign wdog_err_o   = wdog_err_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed table-driven bench for muldiv_hilo_ctrl with simple latency-programmable unit models.
module tb_muldiv_hilo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid_i;
  logic [2:0]  op_i;
  logic [31:0] src1_i, src2_i;
  logic        flush_i;
  logic        mul_start_o, mul_signed_o;
  logic [31:0] mul_op1_o, mul_op2_o;
  logic [63:0] mul_result_i;
  logic        mul_ready_i;
  logic        div_start_o, div_signed_o, div_annul_o;
  logic [31:0] div_op1_o, div_op2_o;
  logic [63:0] div_result_i;
  logic        div_ready_i;
  logic        stall_req_o, hilo_we_o, wdog_err_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_hilo_ctrl #(.WDOG_CYCLES(48), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .op_i(op_i),
    .src1_i(src1_i), .src2_i(src2_i), .flush_i(flush_i),
    .mul_start_o(mul_start_o), .mul_signed_o(mul_signed_o),
    .mul_op1_o(mul_op1_o), .mul_op2_o(mul_op2_o),
    .mul_result_i(mul_result_i), .mul_ready_i(mul_ready_i),
    .div_start_o(div_start_o), .div_signed_o(div_signed_o), .div_annul_o(div_annul_o),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .div_result_i(div_result_i), .div_ready_i(div_ready_i),
    .stall_req_o(stall_req_o), .hilo_we_o(hilo_we_o),
    .hi_o(hi_o), .lo_o(lo_o), .wdog_err_o(wdog_err_o)
  );

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic        sgn;
    logic        starts;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(logic [2:0] op, logic [31:0] a, logic [31:0] b, int lat,
                              logic sgn, logic starts, logic [31:0] hi, logic [31:0] lo);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.lat = lat;
    v.sgn = sgn; v.starts = starts; v.hi = hi; v.lo = lo;
    return v;
  endfunction

  // Unit models: behave like the real multiplier/divider would on the operands the DUT presents.
  function automatic logic [63:0] mul_model(logic [31:0] a, logic [31:0] b, logic s);
    logic signed [63:0] sa, sb;
    sa = s ? {{32{a[31]}}, a} : {32'd0, a};
    sb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return sa * sb;
  endfunction

  function automatic logic [63:0] div_model(logic [31:0] a, logic [31:0] b, logic s);
    logic [31:0] q, r;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int idx, we_idx, we_cnt, busy, start_cnt, wrong_start;
    logic [31:0] got_hi, got_lo;
    logic is_mul;
    is_mul = (v.op == OP_MULT) || (v.op == OP_MULTU);
    idx = 0; we_idx = 0; we_cnt = 0; busy = 0; start_cnt = 0; wrong_start = 0;
    got_hi = '0; got_lo = '0;
    @(negedge clk);
    chk({nm, "_prev_we_clear"}, hilo_we_o, 0);
    ex_valid_i = 1'b1; op_i = v.op; src1_i = v.a; src2_i = v.b;
    #1;
    chk({nm, "_accept_stall"}, stall_req_o, 1);
    while (we_idx == 0 && idx < 200) begin
      @(negedge clk);
      idx++;
      mul_ready_i = 1'b0;
      div_ready_i = 1'b0;
      if (hilo_we_o) begin
        we_cnt++;
        we_idx = idx;
        got_hi = hi_o;
        got_lo = lo_o;
        chk({nm, "_done_stall"}, stall_req_o, 0);
        chk({nm, "_done_starts"}, {mul_start_o, div_start_o}, 0);
      end else if (stall_req_o) begin
        busy++;
      end
      if (is_mul ? div_start_o : mul_start_o) wrong_start++;
      if (mul_start_o || div_start_o) begin
        start_cnt++;
        if (start_cnt == 1) begin
          chk({nm, "_signed"}, is_mul ? mul_signed_o : div_signed_o, v.sgn);
          chk({nm, "_operands"}, is_mul ? {mul_op1_o, mul_op2_o} : {div_op1_o, div_op2_o},
              {v.a, v.b});
        end
        if (start_cnt == v.lat) begin
          if (is_mul) begin
            mul_result_i = mul_model(mul_op1_o, mul_op2_o, mul_signed_o);
            mul_ready_i  = 1'b1;
          end else begin
            div_result_i = div_model(div_op1_o, div_op2_o, div_signed_o);
            div_ready_i  = 1'b1;
          end
        end
      end
    end
    chk({nm, "_we_count"}, we_cnt, 1);
    chk({nm, "_latency"}, we_idx, v.starts ? v.lat + 1 : 1);
    chk({nm, "_busy_cycles"}, busy, v.starts ? v.lat : 0);
    chk({nm, "_start_cycles"}, start_cnt, v.starts ? v.lat : 0);
    chk({nm, "_wrong_unit"}, wrong_start, 0);
    chk({nm, "_hi"}, got_hi, v.hi);
    chk({nm, "_lo"}, got_lo, v.lo);
  endtask

  task automatic flush_seq(input string nm, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] b, input int fidx, input logic with_ready,
                           input logic exp_annul);
    int we_cnt, annul_cnt;
    we_cnt = 0; annul_cnt = 0;
    @(negedge clk);
    ex_valid_i = 1'b1; op_i = op; src1_i = a; src2_i = b;
    for (int i = 1; i <= fidx; i++) begin
      @(negedge clk);
      if (hilo_we_o) we_cnt++;
      if (div_annul_o) annul_cnt++;
    end
    chk({nm, "_busy_before_flush"}, stall_req_o, 1);
    flush_i = 1'b1; ex_valid_i = 1'b0; op_i = 3'b000;
    if (with_ready) begin
      mul_result_i = 64'h0000_0001_0000_0002; mul_ready_i = 1'b1;
      div_result_i = 64'h0000_0003_0000_0004; div_ready_i = 1'b1;
    end
    @(negedge clk);
    flush_i = 1'b0; mul_ready_i = 1'b0; div_ready_i = 1'b0;
    chk({nm, "_annul"}, div_annul_o, exp_annul);
    chk({nm, "_starts_drop"}, {mul_start_o, div_start_o}, 0);
    chk({nm, "_stall_drop"}, stall_req_o, 0);
    if (hilo_we_o) we_cnt++;
    @(negedge clk);
    chk({nm, "_annul_one_cycle"}, div_annul_o, 0);
    if (hilo_we_o) we_cnt++;
    repeat (2) begin
      @(negedge clk);
      if (hilo_we_o) we_cnt++;
    end
    chk({nm, "_no_write"}, we_cnt, 0);
    chk({nm, "_no_early_annul"}, annul_cnt, 0);
  endtask

  task automatic wdog_seq(input string nm, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic exp_annul);
    int busy, we_cnt, annul_cnt;
    busy = 0; we_cnt = 0; annul_cnt = 0;
    @(negedge clk);
    ex_valid_i = 1'b1; op_i = op; src1_i = a; src2_i = b;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (hilo_we_o) we_cnt++;
      if (div_annul_o) annul_cnt++;
      if (i == 1) begin
        ex_valid_i = 1'b0; op_i = 3'b000;
      end
      if (stall_req_o) busy++;
      else break;
    end
    chk({nm, "_busy_cycles"}, busy, 48);
    chk({nm, "_err_set"}, wdog_err_o, 1);
    chk({nm, "_starts_drop"}, {mul_start_o, div_start_o}, 0);
    chk({nm, "_annul"}, annul_cnt, exp_annul ? 1 : 0);
    @(negedge clk);
    if (hilo_we_o) we_cnt++;
    chk({nm, "_annul_one_cycle"}, div_annul_o, 0);
    chk({nm, "_no_write"}, we_cnt, 0);
    chk({nm, "_err_sticky"}, wdog_err_o, 1);
  endtask

  initial begin
    rst = 1'b1; ex_valid_i = 1'b0; op_i = 3'b000; src1_i = '0; src2_i = '0; flush_i = 1'b0;
    mul_result_i = '0; mul_ready_i = 1'b0; div_result_i = '0; div_ready_i = 1'b0;

    vecs[0] = mk(OP_MULT,  32'hFFFF_FFFE, 32'd3,         34, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    vecs[1] = mk(OP_MULTU, 32'hFFFF_FFFE, 32'd3,          5, 1'b0, 1'b1, 32'h0000_0002, 32'hFFFF_FFFA);
    vecs[2] = mk(OP_DIV,   32'hFFFF_FFF9, 32'd2,         33, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    vecs[3] = mk(OP_DIVU,  32'd100,       32'd0,          0, 1'b0, 1'b0, 32'd100,       32'hFFFF_FFFF);
    vecs[4] = mk(OP_DIVU,  32'd100,       32'd7,          3, 1'b0, 1'b1, 32'd2,         32'd14);
    vecs[5] = mk(OP_DIV,   32'd7,         32'hFFFF_FFFE,  2, 1'b1, 1'b1, 32'd1,         32'hFFFF_FFFD);
    vecs[6] = mk(OP_MULT,  32'h0001_0000, 32'h0001_0000,  1, 1'b1, 1'b1, 32'd1,         32'd0);
    vecs[7] = mk(OP_DIV,   32'hDEAD_BEEF, 32'd0,          0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFFF);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_starts", {mul_start_o, div_start_o, div_annul_o, hilo_we_o, wdog_err_o}, 0);
    chk("reset_signed", {mul_signed_o, div_signed_o}, 0);
    chk("reset_mul_ops", {mul_op1_o, mul_op2_o}, 0);
    chk("reset_div_ops", {div_op1_o, div_op2_o}, 0);
    chk("reset_hilo", {hi_o, lo_o}, 0);
    chk("reset_stall", stall_req_o, 0);
    rst = 1'b0;

    // Flush and invalid opcodes must not be accepted in IDLE.
    @(negedge clk);
    ex_valid_i = 1'b1; op_i = OP_MULT; src1_i = 32'd5; src2_i = 32'd6; flush_i = 1'b1;
    #1 chk("idle_flush_stall", stall_req_o, 0);
    @(negedge clk);
    chk("idle_flush_no_start", {mul_start_o, div_start_o}, 0);
    flush_i = 1'b0; op_i = 3'b101;
    #1 chk("idle_badop_stall", stall_req_o, 0);
    @(negedge clk);
    chk("idle_badop_no_start", {mul_start_o, div_start_o, hilo_we_o}, 0);
    op_i = 3'b111;
    #1 chk("idle_op7_stall", stall_req_o, 0);

    for (int i = 0; i < 8; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    flush_seq("div_flush", OP_DIV, 32'd50, 32'd3, 10, 1'b0, 1'b1);
    run_vec("mult_after_flush", mk(OP_MULT, 32'd5, 32'd6, 4, 1'b1, 1'b1, 32'd0, 32'd30));
    flush_seq("mul_flush_ready", OP_MULTU, 32'd9, 32'd9, 4, 1'b1, 1'b0);
    flush_seq("div_flush_ready", OP_DIVU, 32'd9, 32'd4, 6, 1'b1, 1'b1);

    wdog_seq("wdog_mul", OP_MULT, 32'd3, 32'd4, 1'b0);
    run_vec("after_wdog", mk(OP_MULTU, 32'd7, 32'd8, 4, 1'b0, 1'b1, 32'd0, 32'd56));
    chk("wdog_still_set", wdog_err_o, 1);
    wdog_seq("wdog_div", OP_DIVU, 32'd3, 32'd4, 1'b1);

    // Reset in the middle of a divide: starts drop, no annul, error flag cleared.
    @(negedge clk);
    ex_valid_i = 1'b1; op_i = OP_DIV; src1_i = 32'd9; src2_i = 32'd2;
    repeat (5) @(negedge clk);
    chk("rst_mid_busy", div_start_o, 1);
    rst = 1'b1; ex_valid_i = 1'b0; op_i = 3'b000;
    @(negedge clk);
    chk("rst_mid_starts", {mul_start_o, div_start_o}, 0);
    chk("rst_mid_no_annul", div_annul_o, 0);
    chk("rst_mid_stall", stall_req_o, 0);
    chk("rst_clears_wdog", wdog_err_o, 0);
    rst = 1'b0;
    run_vec("after_rst", mk(OP_DIV, 32'hFFFF_FFF9, 32'd2, 7, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD));
    @(negedge clk);
    ex_valid_i = 1'b0; op_i = 3'b000;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
- Sequences the shared multi-cycle multiplier and divider for the EX stage of the 5-stage MIPS core.
- Decodes MULT/MULTU/DIV/DIVU and latches operands.
- Drives the unit start/signed/annul controls and holds the pipeline stall for the whole operation.
- Delivers one HI/LO write per accepted instruction.
- Also handles flush, divide-by-zero bypass and a stuck-unit watchdog.

Parameters:
WDOG_CYCLES, 48, max cycles in a BUSY state before abort; must exceed worst-case unit latency (~35)
CNT_W, 6, width of the watchdog counter; must hold WDOG_CYCLES

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
ex_valid_i  in  1  EX stage holds a valid instruction
op_i  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, others treated as none
src1_i  in  32  rs operand
src2_i  in  32  rt operand
flush_i  in  1  pipeline flush (exception/branch kill)
mul_start_o  out  1  multiplier start, level-held until result taken
mul_signed_o  out  1  signed multiply
mul_op1_o  out  32  latched operand 1 to multiplier
mul_op2_o  out  32  latched operand 2 to multiplier
mul_result_i  in  64  multiplier product {hi,lo}
mul_ready_i  in  1  multiplier result valid
div_start_o  out  1  divider start, level-held
div_signed_o  out  1  signed divide
div_annul_o  out  1  divider abort pulse
div_op1_o  out  32  dividend
div_op2_o  out  32  divisor
div_result_i  in  64  {remainder,quotient}
div_ready_i  in  1  divider result valid
stall_req_o  out  1  stall request to pipeline control
hilo_we_o  out  1  HI/LO write strobe, one cycle
hi_o  out  32  value for HI
lo_o  out  32  value for LO
wdog_err_o  out  1  sticky watchdog error flag

Behaviour:
- States: IDLE, MUL_BUSY, DIV_BUSY, DONE.
- Reset: state=IDLE. All outputs 0, latched operands 0, counter 0, wdog_err_o=0.
- Reset mid-operation drops starts the next cycle; div_annul_o is not pulsed on reset.
- Accept condition (IDLE): ex_valid_i=1, op_i is a valid op, flush_i=0. On accept, latch src1/src2 and the signed flag (MULT/DIV = signed).
- stall_req_o is combinational:
  - 1 in IDLE while the accept condition holds, so the same-cycle stall freezes EX.
  - 1 in MUL_BUSY and DIV_BUSY.
  - 0 in DONE.
- IDLE -> MUL_BUSY on MULT/MULTU. Next cycle mul_start_o=1 with latched operands.
- IDLE -> DIV_BUSY on DIV/DIVU when src2_i != 0; div_start_o=1.
- IDLE -> DONE on DIV/DIVU when src2_i == 0 (bypass; unit not started). Result: hi=src1, lo=32'hFFFFFFFF.
- MUL_BUSY:
  - On mul_ready_i=1: capture hi=result[63:32], lo=result[31:0], drop mul_start_o the next cycle, go to DONE.
  - Start stays high until then.
- DIV_BUSY:
  - On div_ready_i=1: hi=result[63:32] (remainder), lo=result[31:0] (quotient), drop div_start_o, go to DONE.
- DONE:
  - hilo_we_o=1 for exactly this cycle with the captured hi_o/lo_o; starts are 0.
  - ex_valid_i is ignored in this cycle (the completed instruction is leaving EX).
  - Always -> IDLE.
- hilo_we_o is 0 in every other state. hi_o/lo_o hold their last values.
- Flush:
  - flush_i=1 in MUL_BUSY or DIV_BUSY -> IDLE next cycle, starts drop, no HI/LO write.
  - In DIV_BUSY, div_annul_o also pulses 1 for one cycle.
  - flush_i in DONE does not suppress the write, since the instruction has committed.
  - flush_i in IDLE blocks accept.
- Simultaneous ready and flush: flush wins, and the result is discarded.
- Watchdog:
  - The counter clears on entering a BUSY state and increments each BUSY cycle.
  - When it reaches WDOG_CYCLES: go to IDLE, drop start, pulse div_annul_o if dividing, set wdog_err_o, no HI/LO write.
  - wdog_err_o is cleared only by rst.
- Back-to-back: the next mul/div is accepted in the IDLE cycle after DONE. Minimum issue interval = unit latency + 2.
- Latency from accept to hilo_we_o = 1 + unit cycles to ready + 1.

Test Plan:
- MULT src1=0xFFFFFFFE, src2=3, multiplier model ready after 34 cycles -> stall held all cycles, mul_signed_o=1, one hilo_we_o pulse, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU 0xFFFFFFFE x 3 -> mul_signed_o=0, HI=0x00000002, LO=0xFFFFFFFA, stall drops in DONE.
- DIV src1=-7 (0xFFFFFFF9), src2=2 -> div_signed_o=1, HI=0xFFFFFFFF (rem -1), LO=0xFFFFFFFD (quot -3).
- DIVU src1=100, src2=0 -> div_start_o never asserted, DONE after 1 cycle, HI=100, LO=0xFFFFFFFF.
- DIV started, flush_i at cycle 10 -> div_annul_o one-cycle pulse, starts 0 next cycle, no hilo_we_o; the following MULT 5x6 gives LO=30, HI=0.
- Multiplier model never asserts ready -> after 48 BUSY cycles the block is in IDLE, wdog_err_o=1 and stays 1 until rst, no HI/LO write.
